// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port IDs and address legality.
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int          DEFAULT_MEM_BYTES = 1024;
    localparam logic [31:0] WORD_ALIGN_MASK   = 32'h0000_0003;

    // A word access must be aligned and must fit entirely inside the memory.
    function automatic logic addr_illegal(input logic [31:0] addr, input logic [31:0] max_addr);
        return ((addr & WORD_ALIGN_MASK) != 32'd0) || (addr > max_addr);
    endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_pick2
    import data_memory_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = (last_winner == PORT_CPU) ? PORT_DBG : PORT_CPU;
        end else if (req1) begin
            winner = PORT_DBG;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one data-memory port between the CPU and debug ports as IDLE -> ACCESS -> RESP transactions.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        memWrite,
    output logic        memRead,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    output logic        busy
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    state_t      state;
    logic        last_winner;
    logic        id_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        grant_valid;
    logic        grant_id;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_illegal;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_winner (last_winner),
        .valid       (grant_valid),
        .winner      (grant_id)
    );

    always_comb begin
        sel_we      = (grant_id == PORT_DBG) ? we1    : we0;
        sel_addr    = (grant_id == PORT_DBG) ? addr1  : addr0;
        sel_wdata   = (grant_id == PORT_DBG) ? wdata1 : wdata0;
        sel_illegal = addr_illegal(sel_addr, MAX_ADDR);
    end

    // Rejected accesses skip ACCESS entirely so memory is never touched for them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_winner <= PORT_DBG;
            id_q        <= PORT_CPU;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        id_q        <= grant_id;
                        last_winner <= grant_id;
                        we_q        <= sel_we;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        err_q       <= sel_illegal;
                        state       <= sel_illegal ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: state <= ST_RESP;
                ST_RESP:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    logic in_access;
    logic in_resp;
    logic read_ok;

    always_comb begin
        in_access    = (state == ST_ACCESS);
        in_resp      = (state == ST_RESP);
        read_ok      = in_resp && !we_q && !err_q;

        busy         = (state != ST_IDLE);
        memRead      = in_access && !we_q;
        memWrite     = in_access && we_q;
        memAddress   = addr_q;
        memWriteData = wdata_q;

        ack0         = in_resp && (id_q == PORT_CPU);
        ack1         = in_resp && (id_q == PORT_DBG);
        err0         = ack0 && err_q;
        err1         = ack1 && err_q;
        rdata0       = (read_ok && (id_q == PORT_CPU)) ? memReadData : 32'd0;
        rdata1       = (read_ok && (id_q == PORT_DBG)) ? memReadData : 32'd0;
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random traffic checked against a transaction-timeline model.
module tb_data_memory_arbiter;

    localparam int MEM_BYTES = 1024;
    localparam logic [31:0] LIM = 32'(MEM_BYTES - 4);

    logic clk = 1'b0;
    logic reset;
    logic req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic memWrite, memRead;
    logic [31:0] memAddress, memWriteData, memReadData;
    logic busy;

    logic s_req0, s_req1, s_we0, s_we1;
    logic [31:0] s_addr0, s_addr1, s_wdata0, s_wdata1;
    logic s_ack0, s_ack1, s_err0, s_err1;
    logic [31:0] s_rdata0, s_rdata1;
    logic s_memWrite, s_memRead;
    logic [31:0] s_memAddress, s_memWriteData;
    logic [31:0] s_memReadData;
    logic s_busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .memWrite(memWrite), .memRead(memRead),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memReadData(memReadData), .busy(busy)
    );

    data_memory_arbiter #(.MEM_BYTES(256)) dut_small (
        .clk(clk), .reset(reset),
        .req0(s_req0), .req1(s_req1), .we0(s_we0), .we1(s_we1),
        .addr0(s_addr0), .addr1(s_addr1), .wdata0(s_wdata0), .wdata1(s_wdata1),
        .ack0(s_ack0), .ack1(s_ack1), .err0(s_err0), .err1(s_err1),
        .rdata0(s_rdata0), .rdata1(s_rdata1),
        .memWrite(s_memWrite), .memRead(s_memRead),
        .memAddress(s_memAddress), .memWriteData(s_memWriteData),
        .memReadData(s_memReadData), .busy(s_busy)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    // ---------------- memory behind the main DUT (big-endian bytes, registered read)
    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    function automatic logic [31:0] init_word(input int a);
        return {init_byte(a), init_byte(a + 1), init_byte(a + 2), init_byte(a + 3)};
    endfunction

    logic [7:0] mem_bytes [0:MEM_BYTES-1];

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem_bytes[i] = init_byte(i);
        memReadData   = 32'd0;
        s_memReadData = 32'h1234_5678;
    end

    always @(posedge clk) begin
        if (memAddress <= LIM) begin
            if (memWrite) begin
                mem_bytes[int'(memAddress)]     <= memWriteData[31:24];
                mem_bytes[int'(memAddress) + 1] <= memWriteData[23:16];
                mem_bytes[int'(memAddress) + 2] <= memWriteData[15:8];
                mem_bytes[int'(memAddress) + 3] <= memWriteData[7:0];
            end
            if (memRead) begin
                memReadData <= {mem_bytes[int'(memAddress)], mem_bytes[int'(memAddress) + 1],
                                mem_bytes[int'(memAddress) + 2], mem_bytes[int'(memAddress) + 3]};
            end
        end
    end

    // ---------------- reference model: scheduled cycles per transaction
    logic [31:0] ref_mem [int];
    int   cyc = 0;
    int   free_at = 0;
    int   acc_cyc = -1;
    int   ack_cyc = -1;
    logic m_lw = 1'b1;
    logic m_port = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_rdata = 32'd0;

    function automatic logic [31:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (acc_cyc == cyc && !m_err) begin
            if (m_we) ref_mem[int'(m_addr)] = m_wdata;
            else      m_rdata = ref_read(int'(m_addr));
        end
        if (reset) begin
            free_at = cyc + 1;
            acc_cyc = -1;
            ack_cyc = -1;
            m_lw    = 1'b1;
        end else if (cyc >= free_at && (req0 || req1)) begin
            m_port  = (req0 && req1) ? !m_lw : req1;
            m_lw    = m_port;
            m_we    = m_port ? we1 : we0;
            m_addr  = m_port ? addr1 : addr0;
            m_wdata = m_port ? wdata1 : wdata0;
            m_err   = (m_addr % 4 != 0) || (m_addr > LIM);
            if (m_err) begin
                acc_cyc = -1;
                ack_cyc = cyc + 1;
            end else begin
                acc_cyc = cyc + 1;
                ack_cyc = cyc + 2;
            end
            free_at = ack_cyc + 1;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            logic in_acc, in_ack;
            logic [31:0] exp_rd;
            in_acc = (cyc == acc_cyc);
            in_ack = (cyc == ack_cyc);
            exp_rd = (in_ack && !m_we && !m_err) ? m_rdata : 32'd0;
            check("busy", busy, 32'(cyc < free_at));
            check("memRead", memRead, 32'(in_acc && !m_we));
            check("memWrite", memWrite, 32'(in_acc && m_we));
            if (in_acc) check("memAddress", memAddress, m_addr);
            if (in_acc && m_we) check("memWriteData", memWriteData, m_wdata);
            check("ack0", ack0, 32'(in_ack && m_port == 1'b0));
            check("ack1", ack1, 32'(in_ack && m_port == 1'b1));
            check("err0", err0, 32'(in_ack && m_port == 1'b0 && m_err));
            check("err1", err1, 32'(in_ack && m_port == 1'b1 && m_err));
            check("rdata0", rdata0, (m_port == 1'b0) ? exp_rd : 32'd0);
            check("rdata1", rdata1, (m_port == 1'b1) ? exp_rd : 32'd0);
        end
    end

    // ---------------- stimulus helpers
    task automatic set_port(input logic p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Issue one request, then check latency (negedges from request cycle), err, rdata and strobe count.
    task automatic directed(input string nm, input logic p, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int exp_k, input logic exp_err, input logic [31:0] exp_rd);
        int k_ack = 0;
        int strobes = 0;
        logic e = 1'b0;
        logic [31:0] rd = 32'd0;
        @(posedge clk); #1;
        set_port(p, 1'b1, w, a, d);
        for (int k = 1; k <= 8 && k_ack == 0; k++) begin
            @(negedge clk);
            if (memRead || memWrite) strobes++;
            if (p ? ack1 : ack0) begin
                k_ack = k;
                e  = p ? err1 : err0;
                rd = p ? rdata1 : rdata0;
            end
        end
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
        check({nm, "_latency"}, k_ack, exp_k);
        check({nm, "_err"}, e, exp_err);
        check({nm, "_rdata"}, rd, exp_rd);
        check({nm, "_strobes"}, strobes, exp_err ? 0 : 1);
    endtask

    int ack_port_q[$];
    int ack_k_q[$];

    // Hold the pre-driven requests, moving each port to a new address after its ack.
    task automatic run_burst(input int want0, input int want1, input int limit);
        int n0 = 0;
        int n1 = 0;
        logic a0, a1;
        ack_port_q.delete();
        ack_k_q.delete();
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            a0 = ack0;
            a1 = ack1;
            if (a0) begin ack_port_q.push_back(0); ack_k_q.push_back(k); end
            if (a1) begin ack_port_q.push_back(1); ack_k_q.push_back(k); end
            @(posedge clk); #1;
            if (a0) begin n0++; if (n0 >= want0) req0 = 1'b0; else addr0 = addr0 + 8; end
            if (a1) begin n1++; if (n1 >= want1) req1 = 1'b0; else addr1 = addr1 + 8; end
            if (!req0 && !req1) break;
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic small_case(input string nm, input logic [31:0] a, input int exp_k,
                              input logic exp_err, input logic [31:0] exp_rd);
        int k_ack = 0;
        int strobes = 0;
        logic e = 1'b0;
        logic [31:0] rd = 32'd0;
        @(posedge clk); #1;
        s_req0 = 1'b1; s_we0 = 1'b0; s_addr0 = a;
        for (int k = 1; k <= 6 && k_ack == 0; k++) begin
            @(negedge clk);
            if (s_memRead || s_memWrite) strobes++;
            if (s_ack0) begin k_ack = k; e = s_err0; rd = s_rdata0; end
        end
        @(posedge clk); #1;
        s_req0 = 1'b0;
        check({nm, "_latency"}, k_ack, exp_k);
        check({nm, "_err"}, e, exp_err);
        check({nm, "_rdata"}, rd, exp_rd);
        check({nm, "_strobes"}, strobes, exp_err ? 0 : 1);
    endtask

    task automatic requester(input logic p, input int n);
        for (int t = 0; t < n; t++) begin
            int gap;
            int kind;
            logic got;
            logic [31:0] a;
            gap  = $urandom_range(0, 3);
            kind = $urandom_range(0, 99);
            a    = 32'($urandom_range(0, MEM_BYTES / 4 - 1) * 4);
            if (kind < 12) a = a | 32'($urandom_range(1, 3));
            else if (kind < 18) a = 32'(MEM_BYTES + 4 * $urandom_range(0, 100));
            else if (kind < 20) a = 32'hFFFF_FFFC;
            if (gap > 0) begin
                set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
                repeat (gap) @(posedge clk);
                #1;
            end
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                got = p ? ack1 : ack0;
            end
            check(p ? "rand_ack_seen1" : "rand_ack_seen0", got, 1);
            @(posedge clk); #1;
        end
        set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        s_req0 = 0; s_req1 = 0; s_we0 = 0; s_we1 = 0;
        s_addr0 = 0; s_addr1 = 0; s_wdata0 = 0; s_wdata1 = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_memAddress", memAddress, 32'd0);
        check("rst_memWriteData", memWriteData, 32'd0);
        check("rst_ack0", ack0, 0);
        check("rst_rdata1", rdata1, 32'd0);

        directed("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3, 1'b0, 32'd0);
        directed("rd10", 1'b0, 1'b0, 32'h10, 32'd0, 3, 1'b0, 32'hDEAD_BEEF);
        directed("p1_misal", 1'b1, 1'b0, 32'h13, 32'd0, 2, 1'b1, 32'd0);
        directed("rd3fc", 1'b0, 1'b0, 32'h3FC, 32'd0, 3, 1'b0, init_word(32'h3FC));
        directed("rd400", 1'b0, 1'b0, 32'h400, 32'd0, 2, 1'b1, 32'd0);
        directed("p1_wr_top", 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1, 2, 1'b1, 32'd0);

        // contention straight after reset: port 0 first, then strict alternation
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 32'h0, 32'd0);
        set_port(1'b1, 1'b1, 1'b1, 32'h4, 32'h0BAD_F00D);
        run_burst(2, 2, 20);
        check("alt_count", ack_port_q.size(), 4);
        for (int i = 0; i < ack_port_q.size() && i < 4; i++) begin
            check("alt_port", ack_port_q[i], i % 2);
            check("alt_cycle", ack_k_q[i], 3 + 3 * i);
        end

        // reset while port 1's read is in ACCESS
        @(posedge clk); #1;
        set_port(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rstacc_memRead", memRead, 1);
        @(posedge clk); #1 reset = 1'b0;
        set_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("rstacc_busy", busy, 0);
        check("rstacc_ack1", ack1, 0);
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 32'h30, 32'd0);
        set_port(1'b1, 1'b1, 1'b0, 32'h34, 32'd0);
        run_burst(1, 1, 12);
        check("rstacc_count", ack_port_q.size(), 2);
        if (ack_port_q.size() > 0) check("rstacc_first", ack_port_q[0], 0);

        // port 1 streaming alone
        @(posedge clk); #1;
        set_port(1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
        run_burst(0, 3, 15);
        check("p1_stream_count", ack_k_q.size(), 3);
        for (int i = 0; i < ack_k_q.size() && i < 3; i++) check("p1_stream_cycle", ack_k_q[i], 3 + 3 * i);

        // smaller memory instance
        small_case("small_100", 32'h100, 2, 1'b1, 32'd0);
        small_case("small_0fc", 32'hFC, 3, 1'b0, 32'h1234_5678);

        // random traffic with occasional resets
        fork
            requester(1'b0, 60);
            requester(1'b1, 60);
            begin
                repeat (5) begin
                    repeat ($urandom_range(40, 90)) @(posedge clk);
                    #1 reset = 1'b1;
                    @(posedge clk);
                    #1 reset = 1'b0;
                end
            end
        join

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and sequencer in front of the byte-addressed, big-endian data memory (1-cycle registered read, write on clock edge). Shares the single memory port between the CPU load/store stage (port 0) and the debug/loader port (port 1) with round-robin priority. Sequences each access as a fixed 3-state transaction and rejects misaligned or out-of-range word accesses without touching memory.

## Interface
Parameters:
- MEM_BYTES, 1024: memory size in bytes; legal word addresses are 0 to MEM_BYTES-4.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0, req1  in  1  port request; held high until ack seen
- we0, we1  in  1  1 = write, 0 = read; stable while req high
- addr0, addr1  in  32  byte address; stable while req high
- wdata0, wdata1  in  32  write data; stable while req high
- ack0, ack1  out  1  one-cycle completion pulse
- err0, err1  out  1  high with ack when the access was rejected
- rdata0, rdata1  out  32  read data, valid only while ack high and we=0; 0 otherwise
- memWrite, memRead  out  1  memory strobes
- memAddress  out  32  memory byte address
- memWriteData  out  32  memory write data
- memReadData  in  32  memory registered read data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req high at the clock edge, pick winner, latch its we/addr/wdata and ID, set lastWinner = winner. Legal -> ACCESS; illegal -> RESP with error flag set. No req -> stay IDLE.
- Winner: only one req -> that port. Both -> port != lastWinner. lastWinner resets to 1 (port 0 wins the first tie).
- Illegal: addr[1:0] != 0, or addr > MEM_BYTES-4 (unsigned 32-bit compare). Rejected accesses still count as a win.
- ACCESS (1 cycle): memRead = !we, memWrite = we, memAddress/memWriteData from latched values. Always -> RESP.
- RESP (1 cycle): ack of winner = 1; err = error flag; rdata of winner = memReadData for a legal read, 0 for writes and errors. Always -> IDLE.
- Strobes decoded from state, never high outside ACCESS; memWrite and memRead never both high.
- Loser's req is ignored until the next IDLE; no request is dropped.
- Requester must deassert or change req after sampling ack; IDLE samples req only at its own end-edge, so a request dropped at the ack edge is not re-serviced.

## Timing
- Reset values: state IDLE, lastWinner 1, latched addr/wdata/we 0; so all outputs 0 (busy 0, strobes 0, memAddress 0, memWriteData 0, acks/errs 0, rdata 0).
- Latency: req high in cycle N (IDLE) -> strobe in N+1 -> ack in N+2. Error: ack+err in N+1.
- Throughput: one legal transaction per 3 cycles; per port with both contending, one per 6 cycles.
- reset high during ACCESS: memory still performs the access at that edge (memory has no reset); arbiter returns to IDLE, no ack issued, lastWinner = 1.
- reset high during RESP: ack still visible that cycle (combinational from state); next cycle IDLE.
- Requests arriving during ACCESS/RESP wait; their inputs are not sampled until IDLE.

## Structure
- Shared package: state encoding (IDLE/ACCESS/RESP), port IDs (PORT_CPU=0, PORT_DBG=1), default MEM_BYTES, word-alignment mask.
- One natural sub-module: rr_pick2, combinational 2-way round-robin picker (req0, req1, lastWinner -> grant valid, winner ID).
- FSM, latches and output decode in the top.

## Test plan
- Port 0 write addr 0x10 data 0xDEADBEEF -> memWrite high exactly 1 cycle with memAddress 0x10, memWriteData 0xDEADBEEF; ack0 two cycles after req; then port 0 read 0x10 -> ack0 with rdata0 = 0xDEADBEEF, err0 0.
- Both ports request first cycle after reset (port 0 read 0x0, port 1 write 0x4) -> port 0 acked first, port 1 acked 3 cycles later; both held continuously for 4 transactions -> grants alternate 0,1,0,1.
- Port 1 read addr 0x13 -> ack1+err1 one cycle after req, rdata1 0, no memRead/memWrite pulse.
- Port 0 read 0x3FC -> legal, ack0 err0 0; read 0x400 -> ack0+err0, no strobe; MEM_BYTES overridden to 256: 0x100 rejected.
- reset asserted during ACCESS of port 1 read -> no ack1, busy 0 next cycle, then simultaneous requests -> port 0 wins.
- Port 1 holds req with new addr after each ack, port 0 idle -> ack1 every 3 cycles, never two acks in consecutive cycles.
